// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC generator with a one-entry pending redirect slot.
// Exception and flush redirects that arrive while fetch is stalled are parked
// in the slot and applied at the first unstalled edge.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exception_pc_ena,
  input  logic [31:0] exception_pc,
  input  logic        flush_req,
  input  logic [31:0] id2_jmp_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic [1:0]  pend_state,
  output logic [31:0] br_redirect_cnt,
  output logic [31:0] exc_redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_BR  = 2'd1,
    PEND_EXC = 2'd2
  } pend_e;

  pend_e       state_q;
  logic [31:0] slot_q;

  logic        pend_exc;
  logic        pend_br;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        take_exc;
  logic        take_br;
  pend_e       stall_state;
  logic [31:0] stall_slot;

  assign pend_state = state_q;

  // Pick the next fetch PC by priority and work out how a stalled cycle updates the slot
  always_comb begin
    pend_exc    = (state_q == PEND_EXC);
    pend_br     = (state_q == PEND_BR);
    seq_pc      = pc + (pc[2] ? 32'd4 : 32'd8);
    take_exc    = exception_pc_ena | pend_exc;
    take_br     = ~take_exc & (flush_req | pend_br);
    next_pc     = seq_pc;
    stall_state = (pend_exc || pend_br) ? state_q : IDLE;
    stall_slot  = slot_q;

    if (exception_pc_ena)  next_pc = exception_pc;
    else if (pend_exc)     next_pc = slot_q;
    else if (flush_req)    next_pc = id2_jmp_target;
    else if (pend_br)      next_pc = slot_q;
    else if (pred_taken)   next_pc = pred_target;

    if (exception_pc_ena) begin
      stall_state = PEND_EXC;
      stall_slot  = exception_pc;
    end else if (flush_req && !pend_exc) begin
      stall_state = PEND_BR;
      stall_slot  = id2_jmp_target;
    end
  end

  // Registered PC, pending slot, redirect flag and saturating redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= RESET_PC;
      pc_valid         <= 1'b0;
      redirect         <= 1'b0;
      state_q          <= IDLE;
      slot_q           <= 32'd0;
      br_redirect_cnt  <= 32'd0;
      exc_redirect_cnt <= 32'd0;
    end else begin
      pc_valid <= 1'b1;
      if (!stall) begin
        pc       <= next_pc;
        redirect <= take_exc | take_br;
        state_q  <= IDLE;
        slot_q   <= 32'd0;
        if (take_br && (br_redirect_cnt != 32'hffff_ffff))
          br_redirect_cnt <= br_redirect_cnt + 32'd1;
        if (take_exc && (exc_redirect_cnt != 32'hffff_ffff))
          exc_redirect_cnt <= exc_redirect_cnt + 32'd1;
      end else begin
        redirect <= 1'b0;
        state_q  <= stall_state;
        slot_q   <= stall_slot;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        exception_pc_ena = 1'b0;
  logic [31:0] exception_pc = 32'd0;
  logic        flush_req = 1'b0;
  logic [31:0] id2_jmp_target = 32'd0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = 32'd0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic [1:0]  pend_state;
  logic [31:0] br_redirect_cnt;
  logic [31:0] exc_redirect_cnt;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state: what fetch should see, kept as plain values
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_redirect;
  int          m_pend;      // 0 none, 1 branch waiting, 2 exception waiting
  logic [31:0] m_slot;
  logic [31:0] m_br;
  logic [31:0] m_exc;

  pc_redirect_ctrl #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .exception_pc_ena (exception_pc_ena),
    .exception_pc     (exception_pc),
    .flush_req        (flush_req),
    .id2_jmp_target   (id2_jmp_target),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .redirect         (redirect),
    .pend_state       (pend_state),
    .br_redirect_cnt  (br_redirect_cnt),
    .exc_redirect_cnt (exc_redirect_cnt)
  );

  always #5 clk = ~clk;

  // advance one rising edge and settle away from it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    stall = 1'b0; exception_pc_ena = 1'b0; flush_req = 1'b0; pred_taken = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // advance the model by one edge from the currently driven inputs
  task automatic model_step;
    int kind;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'hbfc0_0000; m_valid = 1'b0; m_redirect = 1'b0;
      m_pend = 0; m_slot = 32'd0; m_br = 32'd0; m_exc = 32'd0;
    end else begin
      m_valid = 1'b1;
      if (!stall) begin
        kind = 0;
        tgt  = m_pc + (((m_pc % 8) >= 4) ? 32'd4 : 32'd8);
        if (exception_pc_ena)   begin kind = 2; tgt = exception_pc;   end
        else if (m_pend == 2)   begin kind = 2; tgt = m_slot;         end
        else if (flush_req)     begin kind = 1; tgt = id2_jmp_target; end
        else if (m_pend == 1)   begin kind = 1; tgt = m_slot;         end
        else if (pred_taken)    tgt = pred_target;
        m_pc = tgt;
        m_redirect = (kind != 0);
        if (kind == 1 && m_br != 32'hffff_ffff) m_br = m_br + 1;
        if (kind == 2 && m_exc != 32'hffff_ffff) m_exc = m_exc + 1;
        m_pend = 0; m_slot = 32'd0;
      end else begin
        m_redirect = 1'b0;
        if (exception_pc_ena) begin m_pend = 2; m_slot = exception_pc; end
        else if (flush_req && m_pend != 2) begin m_pend = 1; m_slot = id2_jmp_target; end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b1; exception_pc_ena = 1'b1; exception_pc = 32'h1234_5678;
    flush_req = 1'b1; pred_taken = 1'b1;
    tick(); tick();
    n_vec++;
    if ({pc, pc_valid, redirect, pend_state} !== {32'hbfc0_0000, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("[TB] FAIL reset_state: got pc=%h valid=%b redir=%b pend=%0d, need bfc00000 0 0 0",
               pc, pc_valid, redirect, pend_state);
    end
    n_vec++;
    if ({br_redirect_cnt, exc_redirect_cnt} !== 64'd0) begin
      n_err++;
      $display("[TB] FAIL reset_counters: got br=%h exc=%h, need 0 0", br_redirect_cnt, exc_redirect_cnt);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_sequential;
    tick();
    n_vec++;
    if ({pc, pc_valid} !== {32'hbfc0_0008, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL seq_first: got pc=%h valid=%b, need bfc00008 1", pc, pc_valid);
    end
    tick();
    n_vec++;
    if ({pc, pc_valid} !== {32'hbfc0_0010, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL seq_second: got pc=%h valid=%b, need bfc00010 1", pc, pc_valid);
    end
  endtask

  task automatic test_predict;
    pred_taken = 1'b1; pred_target = 32'hbfc0_0004;
    tick();
    pred_taken = 1'b0;
    tick();
    n_vec++;
    if (pc !== 32'hbfc0_0008) begin
      n_err++;
      $display("[TB] FAIL seq_plus4: got pc=%h, need bfc00008", pc);
    end
    pred_taken = 1'b1; pred_target = 32'hbfc0_0100;
    tick();
    n_vec++;
    if ({pc, redirect} !== {32'hbfc0_0100, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL pred_taken: got pc=%h redir=%b, need bfc00100 0", pc, redirect);
    end
    stall = 1'b1; pred_target = 32'hdead_0000;
    tick();
    n_vec++;
    if ({pc, pend_state} !== {32'hbfc0_0100, 2'd0}) begin
      n_err++;
      $display("[TB] FAIL stall_hold: got pc=%h pend=%0d, need bfc00100 0", pc, pend_state);
    end
    stall = 1'b0; pred_taken = 1'b0;
    tick();
    n_vec++;
    if (pc !== 32'hbfc0_0108) begin
      n_err++;
      $display("[TB] FAIL pred_not_latched: got pc=%h, need bfc00108", pc);
    end
  endtask

  task automatic test_exc_over_branch;
    do_reset();
    stall = 1'b1; flush_req = 1'b1; id2_jmp_target = 32'h8000_1000;
    tick();
    n_vec++;
    if ({pend_state, pc} !== {2'd1, 32'hbfc0_0000}) begin
      n_err++;
      $display("[TB] FAIL pend_br_entry: got pend=%0d pc=%h, need 1 bfc00000", pend_state, pc);
    end
    flush_req = 1'b0; exception_pc_ena = 1'b1; exception_pc = 32'h8000_0180;
    tick();
    exception_pc_ena = 1'b0;
    tick();
    n_vec++;
    if ({pend_state, pc} !== {2'd2, 32'hbfc0_0000}) begin
      n_err++;
      $display("[TB] FAIL pend_exc_upgrade: got pend=%0d pc=%h, need 2 bfc00000", pend_state, pc);
    end
    stall = 1'b0;
    tick();
    n_vec++;
    if ({pc, redirect, pend_state, exc_redirect_cnt, br_redirect_cnt} !==
        {32'h8000_0180, 1'b1, 2'd0, 32'd1, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL exc_applied: got pc=%h redir=%b pend=%0d exc=%0d br=%0d, need 80000180 1 0 1 0",
               pc, redirect, pend_state, exc_redirect_cnt, br_redirect_cnt);
    end
    tick();
    n_vec++;
    if ({pc, redirect} !== {32'h8000_0188, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL redirect_one_cycle: got pc=%h redir=%b, need 80000188 0", pc, redirect);
    end
  endtask

  task automatic test_flush_ignored;
    do_reset();
    stall = 1'b1; exception_pc_ena = 1'b1; exception_pc = 32'h8000_0180;
    tick();
    exception_pc_ena = 1'b0; flush_req = 1'b1; id2_jmp_target = 32'h8000_2000;
    tick();
    n_vec++;
    if (pend_state !== 2'd2) begin
      n_err++;
      $display("[TB] FAIL exc_keeps_slot: got pend=%0d, need 2", pend_state);
    end
    flush_req = 1'b0; stall = 1'b0;
    tick();
    n_vec++;
    if ({pc, pend_state, br_redirect_cnt, exc_redirect_cnt} !== {32'h8000_0180, 2'd0, 32'd0, 32'd1}) begin
      n_err++;
      $display("[TB] FAIL flush_ignored: got pc=%h pend=%0d br=%0d exc=%0d, need 80000180 0 0 1",
               pc, pend_state, br_redirect_cnt, exc_redirect_cnt);
    end
  endtask

  task automatic test_branch_overwrite;
    do_reset();
    stall = 1'b1; flush_req = 1'b1; id2_jmp_target = 32'h8000_1000;
    tick();
    id2_jmp_target = 32'h8000_3000;
    tick();
    flush_req = 1'b0; pred_taken = 1'b1; pred_target = 32'h1234_5678;
    tick();
    n_vec++;
    if ({pend_state, pc} !== {2'd1, 32'hbfc0_0000}) begin
      n_err++;
      $display("[TB] FAIL br_overwrite_hold: got pend=%0d pc=%h, need 1 bfc00000", pend_state, pc);
    end
    stall = 1'b0;
    tick();
    pred_taken = 1'b0;
    n_vec++;
    if ({pc, redirect, br_redirect_cnt, exc_redirect_cnt} !== {32'h8000_3000, 1'b1, 32'd1, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL br_overwrite_apply: got pc=%h redir=%b br=%0d exc=%0d, need 80003000 1 1 0",
               pc, redirect, br_redirect_cnt, exc_redirect_cnt);
    end
  endtask

  task automatic test_simultaneous_and_saturation;
    do_reset();
    exception_pc_ena = 1'b1; exception_pc = 32'h8000_0180;
    flush_req = 1'b1; id2_jmp_target = 32'h8000_5000;
    tick();
    exception_pc_ena = 1'b0; flush_req = 1'b0;
    n_vec++;
    if ({pc, exc_redirect_cnt, br_redirect_cnt} !== {32'h8000_0180, 32'd1, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL simultaneous: got pc=%h exc=%0d br=%0d, need 80000180 1 0",
               pc, exc_redirect_cnt, br_redirect_cnt);
    end
    force dut.br_redirect_cnt = 32'hffff_ffff;
    #1;
    release dut.br_redirect_cnt;
    flush_req = 1'b1; id2_jmp_target = 32'h8000_6000;
    tick();
    flush_req = 1'b0;
    n_vec++;
    if ({pc, br_redirect_cnt} !== {32'h8000_6000, 32'hffff_ffff}) begin
      n_err++;
      $display("[TB] FAIL br_saturate: got pc=%h br=%h, need 80006000 ffffffff", pc, br_redirect_cnt);
    end
    force dut.exc_redirect_cnt = 32'hffff_fffe;
    #1;
    release dut.exc_redirect_cnt;
    exception_pc_ena = 1'b1; exception_pc = 32'h8000_0200;
    tick();
    n_vec++;
    if (exc_redirect_cnt !== 32'hffff_ffff) begin
      n_err++;
      $display("[TB] FAIL exc_reach_max: got exc=%h, need ffffffff", exc_redirect_cnt);
    end
    tick();
    exception_pc_ena = 1'b0;
    n_vec++;
    if (exc_redirect_cnt !== 32'hffff_ffff) begin
      n_err++;
      $display("[TB] FAIL exc_saturate: got exc=%h, need ffffffff", exc_redirect_cnt);
    end
  endtask

  task automatic test_reset_discards_pending;
    do_reset();
    stall = 1'b1; flush_req = 1'b1; id2_jmp_target = 32'h8000_4000;
    tick();
    flush_req = 1'b0; rst = 1'b1;
    tick();
    n_vec++;
    if ({pc, pend_state, pc_valid} !== {32'hbfc0_0000, 2'd0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_clears_pend: got pc=%h pend=%0d valid=%b, need bfc00000 0 0",
               pc, pend_state, pc_valid);
    end
    rst = 1'b0; stall = 1'b0;
    tick();
    n_vec++;
    if ({pc, redirect, br_redirect_cnt} !== {32'hbfc0_0008, 1'b0, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL pend_not_replayed: got pc=%h redir=%b br=%0d, need bfc00008 0 0",
               pc, redirect, br_redirect_cnt);
    end
  endtask

  task automatic test_random;
    rst = 1'b1; idle_inputs();
    model_step();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(99, 0) < 3);
      stall            = ($urandom_range(99, 0) < 40);
      exception_pc_ena = ($urandom_range(99, 0) < 10);
      flush_req        = ($urandom_range(99, 0) < 15);
      pred_taken       = ($urandom_range(99, 0) < 30);
      exception_pc     = $urandom;
      id2_jmp_target   = $urandom;
      pred_target      = $urandom;
      model_step();
      tick();
      n_vec++;
      if ({pc, pc_valid, redirect} !== {m_pc, m_valid, m_redirect}) begin
        n_err++;
        $display("[TB] FAIL rand_pc[%0d]: got pc=%h valid=%b redir=%b, need %h %b %b",
                 i, pc, pc_valid, redirect, m_pc, m_valid, m_redirect);
      end
      n_vec++;
      if (pend_state !== 2'(m_pend)) begin
        n_err++;
        $display("[TB] FAIL rand_pend[%0d]: got %0d, need %0d", i, pend_state, m_pend);
      end
      n_vec++;
      if ({br_redirect_cnt, exc_redirect_cnt} !== {m_br, m_exc}) begin
        n_err++;
        $display("[TB] FAIL rand_cnt[%0d]: got br=%0d exc=%0d, need %0d %0d",
                 i, br_redirect_cnt, exc_redirect_cnt, m_br, m_exc);
      end
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  // run every scenario in order, then report
  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_exc_over_branch();
    test_flush_ignored();
    test_branch_overwrite();
    test_simultaneous_and_saturation();
    test_reset_discards_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, fetch PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  fetch cannot accept a new PC this cycle.
REQ-005 exception_pc_ena  input  1  exception redirect request, single-cycle pulse.
REQ-006 exception_pc  input  32  exception handler target.
REQ-007 flush_req  input  1  branch/jump mispredict redirect request, single-cycle pulse.
REQ-008 id2_jmp_target  input  32  resolved branch/jump target.
REQ-009 pred_taken  input  1  predictor hit for the current pc.
REQ-010 pred_target  input  32  predicted target for the current pc.
REQ-011 pc  output  32  registered fetch PC.
REQ-012 pc_valid  output  1  pc holds a fetchable address.
REQ-013 redirect  output  1  registered; pc was loaded from an exception or flush source in the previous update.
REQ-014 pend_state  output  2  pending-slot state: 0 IDLE, 1 PEND_BR, 2 PEND_EXC.
REQ-015 br_redirect_cnt  output  32  count of applied branch redirects.
REQ-016 exc_redirect_cnt  output  32  count of applied exception redirects.

Function
REQ-017 pc, the pending slot, pend_state and both counters SHALL change only on the rising edge of clk.
REQ-018 Sequential next PC SHALL be pc+4 when pc[2]=1, else pc+8; 32-bit wrap-around, no alignment masking of any target.
REQ-019 With stall=0, pc SHALL load the first true source: exception_pc_ena -> exception_pc; PEND_EXC -> slot; flush_req -> id2_jmp_target; PEND_BR -> slot; pred_taken -> pred_target; else sequential.
REQ-020 With stall=0, pend_state SHALL return to IDLE and the slot SHALL be discarded at the same edge.
REQ-021 With stall=1, pc SHALL hold.
REQ-022 With stall=1, IDLE + exception_pc_ena SHALL latch exception_pc and enter PEND_EXC.
REQ-023 With stall=1, IDLE + flush_req (no exception) SHALL latch id2_jmp_target and enter PEND_BR.
REQ-024 With stall=1, PEND_BR + exception_pc_ena SHALL overwrite the slot and enter PEND_EXC.
REQ-025 With stall=1, PEND_BR + flush_req SHALL overwrite the slot with the newer target and stay PEND_BR.
REQ-026 With stall=1, PEND_EXC + exception_pc_ena SHALL overwrite the slot; PEND_EXC + flush_req SHALL be ignored.
REQ-027 With stall=1 and no request, the slot SHALL hold; pred_taken SHALL never be latched.
REQ-028 Simultaneous exception_pc_ena and flush_req SHALL be treated as an exception only.
REQ-029 redirect SHALL be 1 for exactly the cycle following a pc update whose source was an exception, flush or pending slot; else 0.
REQ-030 br_redirect_cnt SHALL increment by 1 per pc update sourced from flush_req or PEND_BR; exc_redirect_cnt likewise for exception_pc_ena or PEND_EXC.
REQ-031 Both counters SHALL saturate at 32'hffff_ffff.
REQ-032 pend_state value 3 is illegal and SHALL be treated as IDLE.

Reset
REQ-033 rst SHALL set pc=RESET_PC, pc_valid=0, redirect=0, pend_state=IDLE, slot=0, both counters=0, overriding every other input including stall.
REQ-034 pc_valid SHALL become 1 at the first edge after rst deasserts and stay 1 until the next rst.
REQ-035 rst asserted while PEND_BR or PEND_EXC SHALL discard the pending redirect; it SHALL NOT be applied after reset.

Verification
REQ-036 Reset release, stall=0, no requests -> pc: bfc00000, bfc00008, bfc00010; pc_valid 0 then 1.
REQ-037 pc=bfc00004, stall=0 -> pc=bfc00008; pred_taken=1, pred_target=bfc00100 -> pc=bfc00100, redirect=0.
REQ-038 stall=1, flush_req with target 80001000, then exception 80000180 while still stalled; release stall -> pc=80000180, exc_redirect_cnt=1, br_redirect_cnt=0, redirect=1 one cycle.
REQ-039 stall=1, exception 80000180, then flush_req 80002000; release -> pc=80000180, flush ignored, pend_state 2 then 0.
REQ-040 Same-cycle exception_pc_ena and flush_req, stall=0 -> pc=exception_pc, only exc_redirect_cnt increments; br_redirect_cnt forced to ffffffff plus one branch redirect -> remains ffffffff.
REQ-041 PEND_BR held, rst pulsed one cycle -> pc=bfc00000, pend_state=0, pending target never appears on pc.
